// File: rtl/xor_end_stage.sv
// Ascon permutation post-processing stage: applies key/domain-separation XORs
// at phase boundaries, tracks the AEAD phase, counts blocks and emits the tag.
package ascon_pack;
    // Five 64-bit lanes; index gi holds x<gi>.
    typedef logic [4:0][63:0] type_state;

    localparam logic [2:0] OP_PASS      = 3'b000;
    localparam logic [2:0] OP_INIT_END  = 3'b001;
    localparam logic [2:0] OP_AD_END    = 3'b010;
    localparam logic [2:0] OP_TEXT_END  = 3'b011;
    localparam logic [2:0] OP_FINAL_END = 3'b100;
endpackage

module xor_end_stage
    import ascon_pack::*;
#(
    parameter int KEY_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  type_state        state_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [2:0]       op_i,
    input  logic             last_i,
    input  logic             valid_i,
    output logic             ready_o,
    output type_state        state_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [127:0]     tag_o,
    output logic             tag_valid_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_AD   = 2'd1,
        PH_TEXT = 2'd2
    } phase_t;

    phase_t           phase_reg;
    phase_t           phase_next;
    type_state        state_reg;
    logic             valid_reg;
    logic [127:0]     tag_reg;
    logic             tag_valid_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic             accept;
    logic             legal;
    logic             do_init;
    logic             do_final;
    logic             do_dsep;
    logic             cnt_clr;
    logic             cnt_inc;

    logic [63:0]      key_hi;
    logic [63:0]      key_lo;
    logic [63:0]      key_x2;
    logic [63:0]      key_fin;
    type_state        init_mask;
    type_state        fin_mask;
    type_state        lane_mask;
    type_state        state_next;

    // ------------------------------------------------------------------
    // Key slicing; only the two Ascon key sizes are supported.
    // ------------------------------------------------------------------
    assign key_hi = key_i[127:64];
    assign key_lo = key_i[63:0];

    generate
        if (KEY_W == 160) begin : g_key160
            assign key_x2  = {32'h0, key_i[159:128]};
            assign key_fin = key_i[KEY_W-97:KEY_W-160];
        end else if (KEY_W == 128) begin : g_key128
            assign key_x2  = 64'h0;
            assign key_fin = key_i[127:64];
        end else begin : g_key_bad
            $error("xor_end_stage: KEY_W must be 128 or 160");
            assign key_x2  = 64'h0;
            assign key_fin = 64'h0;
        end
    endgenerate

    assign init_mask = {key_lo, key_hi, key_x2, 64'h0, 64'h0};
    assign fin_mask  = {key_lo, key_fin, 64'h0, 64'h0, 64'h0};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign ready_o = ~valid_reg | ready_i;
    assign accept  = valid_i & ready_o;

    // ------------------------------------------------------------------
    // Op decode against the current phase. Anything not legal leaves every
    // side effect off, so the state passes straight through.
    // ------------------------------------------------------------------
    always_comb begin
        legal      = 1'b0;
        do_init    = 1'b0;
        do_final   = 1'b0;
        do_dsep    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        phase_next = phase_reg;
        case (op_i)
            OP_PASS: begin
                legal = 1'b1;
            end
            OP_INIT_END: begin
                legal      = 1'b1;
                do_init    = 1'b1;
                do_dsep    = last_i;
                cnt_clr    = 1'b1;
                phase_next = last_i ? PH_TEXT : PH_AD;
            end
            OP_AD_END: begin
                if (phase_reg == PH_AD) begin
                    legal   = 1'b1;
                    do_dsep = last_i;
                    cnt_inc = 1'b1;
                    if (last_i) begin
                        phase_next = PH_TEXT;
                    end
                end
            end
            OP_TEXT_END: begin
                if (phase_reg == PH_TEXT) begin
                    legal   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            OP_FINAL_END: begin
                if (phase_reg == PH_TEXT) begin
                    legal      = 1'b1;
                    do_final   = 1'b1;
                    phase_next = PH_IDLE;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane XOR datapath
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_lane
            logic [63:0] dsep_bit;
            assign dsep_bit = (gi == 4 && do_dsep) ? 64'h1 : 64'h0;
            assign lane_mask[gi] = (do_init  ? init_mask[gi] : 64'h0)
                                 ^ (do_final ? fin_mask[gi]  : 64'h0)
                                 ^ dsep_bit;
            assign state_next[gi] = state_i[gi] ^ lane_mask[gi];
        end
    endgenerate

    // Saturating block counter
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (cnt_inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register and phase FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            phase_reg     <= PH_IDLE;
            state_reg     <= '0;
            valid_reg     <= 1'b0;
            tag_reg       <= '0;
            tag_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else if (accept) begin
            phase_reg     <= phase_next;
            state_reg     <= state_next;
            valid_reg     <= 1'b1;
            tag_valid_reg <= do_final;
            err_reg       <= ~legal;
            cnt_reg       <= cnt_next;
            if (do_final) begin
                tag_reg <= {state_next[3], state_next[4]};
            end
        end else if (ready_i) begin
            // Beat consumed with nothing behind it: drop qualifiers, keep data.
            valid_reg     <= 1'b0;
            tag_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end
    end

    assign state_o     = state_reg;
    assign valid_o     = valid_reg;
    assign tag_o       = tag_reg;
    assign tag_valid_o = tag_valid_reg;
    assign err_o       = err_reg;
    assign blk_cnt_o   = cnt_reg;

endmodule

// File: tb/tb_xor_end_stage.sv
// Directed bench for xor_end_stage: a 128-bit-key instance and a 160-bit-key
// instance with a 2-bit counter share the upstream/downstream inputs.
`timescale 1ns/1ps
module tb_xor_end_stage;
    import ascon_pack::*;

    logic           clk;
    logic           rstn;
    type_state      state_i;
    logic [127:0]   key128;
    logic [159:0]   key160;
    logic [2:0]     op_i;
    logic           last_i;
    logic           valid_i;
    logic           ready_i;

    logic           ready_a, valid_a, tag_valid_a, err_a;
    type_state      state_a;
    logic [127:0]   tag_a;
    logic [15:0]    cnt_a;

    logic           ready_b, valid_b, tag_valid_b, err_b;
    type_state      state_b;
    logic [127:0]   tag_b;
    logic [1:0]     cnt_b;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K_SEQ = 128'h000102030405060708090A0B0C0D0E0F;
    localparam type_state S_A  = {64'h4444444444444444, 64'h3333333333333333,
                                  64'h2222222222222222, 64'h1111111111111111,
                                  64'h0F0F0F0F0F0F0F0F};
    localparam type_state S_F  = {64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
                                  64'h5555555555555555, 64'h6666666666666666,
                                  64'h7777777777777777};
    localparam type_state S_P  = {64'hA5A5A5A5A5A5A5A5, 64'h0, 64'h0, 64'h0,
                                  64'h123456789ABCDEF0};

    xor_end_stage #(.KEY_W(128), .CNT_W(16)) dut (
        .clock_i(clk), .resetb_i(rstn), .state_i(state_i), .key_i(key128),
        .op_i(op_i), .last_i(last_i), .valid_i(valid_i), .ready_o(ready_a),
        .state_o(state_a), .valid_o(valid_a), .ready_i(ready_i),
        .tag_o(tag_a), .tag_valid_o(tag_valid_a), .err_o(err_a),
        .blk_cnt_o(cnt_a)
    );

    xor_end_stage #(.KEY_W(160), .CNT_W(2)) dut160 (
        .clock_i(clk), .resetb_i(rstn), .state_i(state_i), .key_i(key160),
        .op_i(op_i), .last_i(last_i), .valid_i(valid_i), .ready_o(ready_b),
        .state_o(state_b), .valid_o(valid_b), .ready_i(ready_i),
        .tag_o(tag_b), .tag_valid_o(tag_valid_b), .err_o(err_b),
        .blk_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [319:0] got,
                            input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One accepted beat; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic last, input type_state st);
        op_i    = op;
        last_i  = last;
        state_i = st;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        type_state exp_s;
        rstn    = 1'b0;
        ready_i = 1'b1;
        valid_i = 1'b0;
        op_i    = OP_PASS;
        last_i  = 1'b0;
        state_i = '0;
        key128  = K_SEQ;
        key160  = {32'hDEADBEEF, 128'h0};
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", valid_a, 0);
        check_eq("rst_tag_valid", tag_valid_a, 0);
        check_eq("rst_err", err_a, 0);
        check_eq("rst_state", state_a, 0);
        check_eq("rst_tag", tag_a, 0);
        check_eq("rst_cnt", cnt_a, 0);
        check_eq("rst_ready", ready_a, 1);
        rstn = 1'b1;

        // Key absorption at end of initialisation, AD follows
        send(OP_INIT_END, 1'b0, '0);
        exp_s = {64'h08090A0B0C0D0E0F, 64'h0001020304050607, 64'h0, 64'h0, 64'h0};
        check_eq("init_valid", valid_a, 1);
        check_eq("init_state", state_a, exp_s);
        check_eq("init_err", err_a, 0);
        check_eq("init_cnt", cnt_a, 0);
        check_eq("init_tag_valid", tag_valid_a, 0);

        send(OP_AD_END, 1'b0, S_A);
        check_eq("ad_state", state_a, S_A);
        check_eq("ad_err", err_a, 0);
        check_eq("ad_cnt", cnt_a, 1);

        send(OP_AD_END, 1'b1, S_A);
        exp_s = {64'h4444444444444445, 64'h3333333333333333, 64'h2222222222222222,
                 64'h1111111111111111, 64'h0F0F0F0F0F0F0F0F};
        check_eq("adlast_state", state_a, exp_s);
        check_eq("adlast_cnt", cnt_a, 2);

        send(OP_TEXT_END, 1'b0, S_A);
        check_eq("text_state", state_a, S_A);
        check_eq("text_err", err_a, 0);
        check_eq("text_cnt", cnt_a, 3);

        // Finalisation, then stall the tag beat for three cycles
        send(OP_FINAL_END, 1'b0, S_F);
        exp_s = {64'h08090A0B0C0D0E0F, 64'hFFFEFDFCFBFAF9F8, 64'h5555555555555555,
                 64'h6666666666666666, 64'h7777777777777777};
        check_eq("final_state", state_a, exp_s);
        check_eq("final_tag", tag_a, 128'hFFFEFDFCFBFAF9F8_08090A0B0C0D0E0F);
        check_eq("final_tag_valid", tag_valid_a, 1);
        check_eq("final_err", err_a, 0);
        ready_i = 1'b0;
        op_i    = OP_PASS;
        last_i  = 1'b0;
        state_i = S_P;
        valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_eq("stall_ready", ready_a, 0);
            check_eq("stall_valid", valid_a, 1);
            check_eq("stall_tag", tag_a, 128'hFFFEFDFCFBFAF9F8_08090A0B0C0D0E0F);
            check_eq("stall_tag_valid", tag_valid_a, 1);
            check_eq("stall_state", state_a, exp_s);
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check_eq("nobubble_valid", valid_a, 1);
        check_eq("nobubble_state", state_a, S_P);
        check_eq("nobubble_tag_valid", tag_valid_a, 0);
        check_eq("tag_retained", tag_a, 128'hFFFEFDFCFBFAF9F8_08090A0B0C0D0E0F);
        @(posedge clk);
        #1;
        check_eq("drain_valid", valid_a, 0);

        // Illegal ops from IDLE
        send(OP_AD_END, 1'b0, S_A);
        check_eq("idle_ad_err", err_a, 1);
        check_eq("idle_ad_state", state_a, S_A);
        check_eq("idle_ad_cnt", cnt_a, 3);
        send(3'b111, 1'b0, S_P);
        check_eq("bad_op_err", err_a, 1);
        check_eq("bad_op_state", state_a, S_P);
        send(OP_TEXT_END, 1'b0, S_A);
        check_eq("idle_text_err", err_a, 1);
        send(OP_PASS, 1'b0, S_A);
        check_eq("pass_err", err_a, 0);

        // No-AD initialisation jumps straight to TEXT
        key128 = '0;
        send(OP_INIT_END, 1'b1, '0);
        check_eq("noad_state", state_a, {64'h1, 64'h0, 64'h0, 64'h0, 64'h0});
        check_eq("noad_cnt", cnt_a, 0);
        send(OP_TEXT_END, 1'b0, S_A);
        check_eq("noad_text_err", err_a, 0);
        check_eq("noad_text_cnt", cnt_a, 1);

        // Back-to-back stream into AD, with a reset pulse mid-stream
        key128 = K_SEQ;
        send(OP_INIT_END, 1'b0, '0);
        op_i    = OP_PASS;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            state_i    = '0;
            state_i[0] = 64'(i + 1);
            @(posedge clk);
            #1;
            check_eq("stream_valid", valid_a, 1);
            check_eq("stream_x0", state_a[0], 64'(i + 1));
            if (i == 4) begin
                rstn = 1'b0;
                #1;
                check_eq("midrst_valid", valid_a, 0);
                check_eq("midrst_state", state_a, 0);
                #1;
                rstn = 1'b1;
            end
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stream_drain", valid_a, 0);
        send(OP_AD_END, 1'b0, S_A);
        check_eq("post_rst_idle_err", err_a, 1);

        // 160-bit key: extra key word into x2; 2-bit counter saturates
        send(OP_INIT_END, 1'b0, '0);
        check_eq("k160_x2", state_b[2], 64'h00000000DEADBEEF);
        check_eq("k160_x3", state_b[3], 64'h0);
        check_eq("k160_x4", state_b[4], 64'h0);
        check_eq("k160_cnt", cnt_b, 0);
        for (int i = 0; i < 4; i++) begin
            send(OP_AD_END, 1'b0, S_A);
            check_eq("sat_cnt", cnt_b, (i < 3) ? (i + 1) : 3);
            check_eq("sat_err", err_b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor_end_stage.md
XOR_END_STAGE -- requirements
Module: xor_end_stage

Interface
REQ-001 SHALL have parameter KEY_W, default 128; key width, legal values 128 (Ascon-128) or 160 (Ascon-80pq); any other value SHALL fail elaboration.
REQ-002 SHALL have parameter CNT_W, default 16; width of the processed-block counter.
REQ-003 SHALL have port clock_i, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port resetb_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port state_i, input, type_state (5x64, ascon_pack), permutation output to post-process.
REQ-006 SHALL have port key_i, input, KEY_W, secret key, sampled on accept.
REQ-007 SHALL have port op_i, input, 3; 000 PASS, 001 INIT_END, 010 AD_END, 011 TEXT_END, 100 FINAL_END, others illegal.
REQ-008 SHALL have port last_i, input, 1; with INIT_END means "no AD"; with AD_END means "last AD block"; ignored otherwise.
REQ-009 SHALL have ports valid_i (input, 1) and ready_o (output, 1), the upstream handshake.
REQ-010 SHALL have ports state_o (output, type_state), valid_o (output, 1) and ready_i (input, 1), the registered downstream handshake.
REQ-011 SHALL have ports tag_o (output, 128, tag) and tag_valid_o (output, 1, qualifies tag_o).
REQ-012 SHALL have port err_o, output, 1; the current output beat resulted from an illegal op.
REQ-013 SHALL have port blk_cnt_o, output, CNT_W; AD+TEXT blocks accepted since the last INIT_END.

Function
REQ-014 An accept SHALL occur on a rising edge with valid_i=1 and ready_o=1; ready_o SHALL equal (!valid_o | ready_i), combinationally.
REQ-015 Latency SHALL be one cycle: an accepted beat SHALL appear on state_o with valid_o=1 in the following cycle.
REQ-016 While valid_o=1 and ready_i=0, state_o, tag_o, tag_valid_o and err_o SHALL hold stable; valid_o SHALL clear when it is consumed with no new accept.
REQ-017 Phase FSM SHALL have the states IDLE, AD, TEXT; it SHALL change only on accept.
REQ-018 PASS SHALL be legal in every phase: state_o=state_i, phase unchanged.
REQ-019 INIT_END SHALL be legal in every phase and SHALL XOR the key into the state: x3^=K[127:64], x4^=K[63:0]; with KEY_W=160, additionally x2^={32'h0,K[159:128]}.
REQ-020 INIT_END with last_i=1 SHALL also apply the domain separation x4^=64'h1 and go to TEXT; with last_i=0 it SHALL go to AD; it SHALL clear blk_cnt_o to 0.
REQ-021 AD_END SHALL be legal only in AD: pass-through, blk_cnt_o+1; with last_i=1 it SHALL apply x4^=64'h1 and go to TEXT.
REQ-022 TEXT_END SHALL be legal only in TEXT: pass-through, blk_cnt_o+1.
REQ-023 FINAL_END SHALL be legal only in TEXT: x3^=K[KEY_W-97:KEY_W-160], x4^=K[63:0] (for KEY_W=128 this is K[127:64]); tag_o SHALL equal {x3',x4'}, tag_valid_o=1 for that beat, and the phase SHALL go to IDLE.
REQ-024 tag_valid_o SHALL be 0 on every non-FINAL_END beat; tag_o SHALL retain its last value.
REQ-025 An illegal op (bad encoding, or legal op in the wrong phase) SHALL pass state_i through unchanged with err_o=1 for that beat; phase and counter SHALL be unchanged.
REQ-026 blk_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-027 A simultaneous accept and downstream consume SHALL replace the output register in the same edge with no bubble.

Reset
REQ-028 On resetb_i=0, asynchronously: valid_o=0, tag_valid_o=0, err_o=0, state_o=all-zero, tag_o=0, blk_cnt_o=0, phase=IDLE.
REQ-029 Reset asserted mid-stream SHALL drop any held output beat; the first accept after release SHALL be judged from IDLE.

Verification
REQ-030 KEY_W=128, K=0x000102..0F, state_i=0, INIT_END last_i=0 -> next cycle x3=0x0001020304050607, x4=0x08090A0B0C0D0E0F, phase AD, blk_cnt_o=0.
REQ-031 INIT_END last_i=1 with state_i=0 and K=0 -> x4=64'h1; then TEXT_END -> err_o=0 and blk_cnt_o=1.
REQ-032 From IDLE, AD_END -> err_o=1, state_o=state_i, phase stays IDLE; op_i=3'b111 -> err_o=1.
REQ-033 Sequence INIT_END, AD_END(last), TEXT_END, FINAL_END with ready_i held 0 for 3 cycles on the FINAL beat -> tag_o/tag_valid_o stable throughout, ready_o=0, then phase IDLE.
REQ-034 KEY_W=160, K[159:128]=32'hDEADBEEF, INIT_END on zero state -> x2=64'h00000000DEADBEEF.
REQ-035 Continuous valid_i=ready_i=1 for 10 beats -> 10 outputs in consecutive cycles; assert resetb_i on beat 5 -> valid_o=0 immediately.
